comp_n_bit_seq: RTL and testbench

COMP_N_BIT_SEQ -- requirements
Module: comp_n_bit_seq

---
 rtl/comp_pkg.sv | 14 +
 rtl/comp_n_bit_seq_if.sv | 27 ++
 rtl/comp_chunk.sv | 16 +
 rtl/comp_n_bit_seq.sv | 145 ++++++++++++++
 tb/tb_comp_n_bit_seq.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared FSM encoding and default sizes for the chunked comparator
package comp_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_CHUNK  = 4;
    localparam int DEF_SIGNED = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comp_n_bit_seq_if.sv
// rtl/comp_n_bit_seq_if.sv - request/result bundle between a requester and comp_n_bit_seq
interface comp_n_bit_seq_if
    import comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             a_lt_b;

    modport master (
        output start, a, b,
        input  busy, done, a_eq_b, a_gt_b, a_lt_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_eq_b, a_gt_b, a_lt_b
    );

endinterface

// File: rtl/comp_chunk.sv
// rtl/comp_chunk.sv - combinational unsigned magnitude comparator for one chunk
module comp_chunk
    import comp_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             gt
);

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/comp_n_bit_seq.sv
// rtl/comp_n_bit_seq.sv - sequential MSB-first chunked comparator; optional macro COMP_EARLY_EXIT_EN
module comp_n_bit_seq
    import comp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CHUNK  = DEF_CHUNK,
    parameter int SIGNED = DEF_SIGNED
) (
    input  logic            clk,
    input  logic            reset,
    comp_n_bit_seq_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] SIGN_MASK = CHUNK'(1) << (CHUNK - 1);

    // Refuse to build when the operand does not split into whole chunks
    if (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK)) begin : g_bad_width
        $error("comp_n_bit_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDXW-1:0]  idx;

    logic             gt_s;
    logic             lt_s;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic             c_eq;
    logic             c_gt;
    logic             decided;
    logic             run_last;
    logic             fin_gt;
    logic             fin_lt;
    logic             accept;

    assign accept  = (state == ST_IDLE) && bus.start;
    assign decided = gt_s || lt_s;

    // Current chunk of each operand; the top chunk gets its sign bit flipped so
    // two's complement order maps onto unsigned order
    always_comb begin
        a_c = a_r[idx*CHUNK +: CHUNK];
        b_c = b_r[idx*CHUNK +: CHUNK];
        if ((SIGNED != 0) && (idx == IDX_TOP)) begin
            a_c = a_c ^ SIGN_MASK;
            b_c = b_c ^ SIGN_MASK;
        end
    end

    comp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (a_c),
        .b  (b_c),
        .eq (c_eq),
        .gt (c_gt)
    );

`ifdef COMP_EARLY_EXIT_EN
    // Any difference decides the result, so stop as soon as one is seen
    assign run_last = (idx == '0) || !c_eq;
`else
    assign run_last = (idx == '0);
`endif

    // An earlier decision wins; otherwise the chunk on hand decides (or ties)
    assign fin_gt = decided ? gt_s : (!c_eq && c_gt);
    assign fin_lt = decided ? lt_s : (!c_eq && !c_gt);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE waits for start, RUN walks the chunks, DONE lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (run_last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture and chunk index; no reset needed, always loaded before use
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= bus.a;
            b_r <= bus.b;
            idx <= IDX_TOP;
        end else if (state == ST_RUN) begin
            idx <= idx - IDXW'(1);
        end
    end

    // Sticky decision and result flags; results clear when a new request is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            gt_s <= 1'b0;
            lt_s <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else if (accept) begin
            gt_s <= 1'b0;
            lt_s <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
        end else if (state == ST_RUN) begin
            if (!decided && !c_eq) begin
                gt_s <= c_gt;
                lt_s <= !c_gt;
            end
            if (run_last) begin
                eq_q <= !fin_gt && !fin_lt;
                gt_q <= fin_gt;
                lt_q <= fin_lt;
            end
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE);
    assign bus.a_eq_b = eq_q;
    assign bus.a_gt_b = gt_q;
    assign bus.a_lt_b = lt_q;

endmodule

// File: tb/tb_comp_n_bit_seq.sv
// tb/tb_comp_n_bit_seq.sv - scoreboard bench for comp_n_bit_seq, unsigned and signed instances
module tb_comp_n_bit_seq;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    typedef struct {
        logic [2:0] flags;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    exp_t         q_u[$];
    exp_t         q_s[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    comp_n_bit_seq_if #(.WIDTH(W)) bus_u ();
    comp_n_bit_seq_if #(.WIDTH(W)) bus_s ();

    assign bus_u.start = start;
    assign bus_u.a     = a;
    assign bus_u.b     = b;
    assign bus_s.start = start;
    assign bus_s.a     = a;
    assign bus_s.b     = b;

    comp_n_bit_seq #(.WIDTH(W), .CHUNK(C), .SIGNED(0)) dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_u)
    );

    comp_n_bit_seq #(.WIDTH(W), .CHUNK(C), .SIGNED(1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {eq,gt,lt} straight from numeric ordering
    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        if (sgn) begin
            if ($signed(x) > $signed(y)) return 3'b010;
            if ($signed(x) < $signed(y)) return 3'b001;
        end else begin
            if (x > y) return 3'b010;
            if (x < y) return 3'b001;
        end
        return 3'b100;
    endfunction

    // Chunks examined: all of them, or up to the first differing one with early exit
    function automatic int ref_chunks(input logic [W-1:0] x, input logic [W-1:0] y);
        int ex = N;
        bit found = 1'b0;
        bit early;
`ifdef COMP_EARLY_EXIT_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && (x[i*C +: C] != y[i*C +: C])) begin
                found = 1'b1;
                ex = N - i;
            end
        end
        return early ? ex : N;
    endfunction

    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input int t);
        exp_t e;
        e.cyc   = t + ref_chunks(x, y);
        e.flags = ref_flags(x, y, 1'b0);
        q_u.push_back(e);
        e.flags = ref_flags(x, y, 1'b1);
        q_s.push_back(e);
    endtask

    // Present one start pulse once the DUT is idle; t is the accepting edge
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit push, output int t);
        int g = 0;
        @(negedge clk);
        while (bus_u.busy && g < 50) begin
            g++;
            @(negedge clk);
        end
        if (g >= 50) check("issue_wait_timeout", 32'd1, 32'd0);
        start = 1'b1;
        a = x;
        b = y;
        t = cyc + 1;
        if (push) push_exp(x, y, t);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((q_u.size() != 0 || q_s.size() != 0 || bus_u.busy) && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (g >= 200) check("drain_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus_u.done === 1'b1) begin
            if (q_u.size() == 0) begin
                check("u_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_u.pop_front();
                check("u_flags", {bus_u.a_eq_b, bus_u.a_gt_b, bus_u.a_lt_b}, e.flags);
                check("u_latency", cyc, e.cyc);
            end
        end
        if (bus_s.done === 1'b1) begin
            if (q_s.size() == 0) begin
                check("s_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q_s.pop_front();
                check("s_flags", {bus_s.a_eq_b, bus_s.a_gt_b, bus_s.a_lt_b}, e.flags);
                check("s_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        int cnt;
        int g;
        int k;
        logic [W-1:0] x;
        logic [W-1:0] y;

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", bus_u.busy, 0);
        check("rst_done", bus_u.done, 0);
        check("rst_flags_u", {bus_u.a_eq_b, bus_u.a_gt_b, bus_u.a_lt_b}, 0);
        check("rst_flags_s", {bus_s.a_eq_b, bus_s.a_gt_b, bus_s.a_lt_b}, 0);

        // Equal operands: busy spans the RUN cycles plus DONE
        issue(16'h1234, 16'h1234, 1'b1, t);
        cnt = 0;
        while (bus_u.busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", cnt, N + 1);
        wait_idle();

        issue(16'h8000, 16'h7FFF, 1'b1, t);
        wait_idle();
        issue(16'hFFFF, 16'h0001, 1'b1, t);
        wait_idle();
        issue(16'h00A5, 16'h00A4, 1'b1, t);
        wait_idle();

        // Results hold while idle, then clear on the edge taking the next start
        repeat (3) @(negedge clk);
        check("hold_flags_u", {bus_u.a_eq_b, bus_u.a_gt_b, bus_u.a_lt_b}, 3'b010);
        check("hold_flags_s", {bus_s.a_eq_b, bus_s.a_gt_b, bus_s.a_lt_b}, 3'b010);
        issue(16'h0001, 16'h0002, 1'b1, t);
        check("clear_on_start", {bus_u.a_eq_b, bus_u.a_gt_b, bus_u.a_lt_b}, 3'b000);
        wait_idle();

        // A start pulse while busy is ignored
        issue(16'h5A5A, 16'h5A50, 1'b1, t);
        start = 1'b1;
        a = 16'h0000;
        b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset in the second RUN cycle aborts silently
        issue(16'h1234, 16'h1235, 1'b0, t);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", bus_u.busy, 0);
        check("abort_done", bus_u.done, 0);
        check("abort_flags_u", {bus_u.a_eq_b, bus_u.a_gt_b, bus_u.a_lt_b}, 0);
        check("abort_flags_s", {bus_s.a_eq_b, bus_s.a_gt_b, bus_s.a_lt_b}, 0);
        issue(16'h1234, 16'h1235, 1'b1, t);
        wait_idle();

        // Start held high: second operation accepted after one IDLE cycle
        @(negedge clk);
        start = 1'b1;
        a = 16'hABCD;
        b = 16'hABCF;
        t = cyc + 1;
        push_exp(a, b, t);
        t2 = t + ref_chunks(a, b) + 2;
        push_exp(a, b, t2);
        g = 0;
        while (cyc < t2 && g < 100) begin
            g++;
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Random operands: equal, one chunk perturbed, or unrelated
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            case ($urandom_range(0, 2))
                0: y = x;
                1: begin
                    y = x;
                    k = $urandom_range(0, N - 1);
                    y[k*C +: C] = y[k*C +: C] ^ C'($urandom_range(1, 15));
                end
                default: y = W'($urandom);
            endcase
            issue(x, y, 1'b1, t);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
